// File: rtl/cnu_pkg.sv
// Shared constants, row-result record and message arithmetic for the check-node
// output stage.
package cnu_pkg;

    localparam int CNU_DATA_W = 8;
    localparam int CNU_IDX_W  = 8;
    localparam int CNU_D      = 5;
    localparam int CNU_OFFSET = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } cnu_state_t;

    // s caches the row parity so each edge only needs one XOR for its sign.
    typedef struct packed {
        logic [CNU_DATA_W-1:0] min;
        logic [CNU_DATA_W-1:0] min2;
        logic [CNU_IDX_W-1:0]  min_idx;
        logic [CNU_D-1:0]      signs;
        logic                  s;
    } cnu_row_t;

    localparam logic [CNU_DATA_W-1:0] CNU_OFFSET_V = CNU_DATA_W'(CNU_OFFSET);

    function automatic logic [CNU_DATA_W-1:0] cnu_offset_sat(input logic [CNU_DATA_W-1:0] mag);
        return (mag > CNU_OFFSET_V) ? (mag - CNU_OFFSET_V) : '0;
    endfunction

    // A zero magnitude always maps to +0, never to the bare sign bit.
    function automatic logic [CNU_DATA_W:0] cnu_to_twos(input logic sgn,
                                                        input logic [CNU_DATA_W-1:0] magc);
        logic [CNU_DATA_W:0] ext;
        ext = {1'b0, magc};
        return (sgn && (magc != '0)) ? (~ext + 1'b1) : ext;
    endfunction

endpackage

// File: rtl/cnu_msg_fmt.sv
// Formats one offset-min-sum check-to-variable message for edge k of a stored
// row: magnitude select, offset saturation and sign application.
module cnu_msg_fmt
    import cnu_pkg::*;
(
    input  cnu_row_t              row,
    input  logic [CNU_IDX_W-1:0]  k,
    output logic [CNU_DATA_W:0]   msg
);

    localparam logic [CNU_IDX_W-1:0] D_IDX = CNU_IDX_W'(CNU_D);

    logic [CNU_DATA_W-1:0] mag;
    logic [CNU_DATA_W-1:0] magc;
    logic                  sgn_k;

    always_comb begin
        sgn_k = 1'b0;
        for (int i = 0; i < CNU_D; i++) begin
            if (k == CNU_IDX_W'(i)) begin
                sgn_k = row.signs[i];
            end
        end

        // An out-of-range min_idx means no edge owns min, so all get min.
        if ((row.min_idx < D_IDX) && (row.min_idx == k)) begin
            mag = row.min2;
        end else begin
            mag = row.min;
        end

        magc = cnu_offset_sat(mag);
        msg  = cnu_to_twos(row.s ^ sgn_k, magc);
    end

endmodule

// File: rtl/cnu_msg_gen.sv
// Check-node output stage: buffers row results in an active/pending pair and
// streams D signed messages per row under a valid/ready handshake.
module cnu_msg_gen
    import cnu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CNU_DATA_W-1:0] min,
    input  logic [CNU_DATA_W-1:0] min2,
    input  logic [CNU_IDX_W-1:0]  min_idx,
    input  logic [CNU_D-1:0]      signs,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNU_DATA_W:0]   out_msg,
    output logic [CNU_IDX_W-1:0]  out_idx,
    output logic                  out_last
);

    localparam logic [CNU_IDX_W-1:0] LAST_IDX = CNU_IDX_W'(CNU_D - 1);

    cnu_state_t            state_q, state_d;
    cnu_row_t              act_q, act_d;
    cnu_row_t              pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [CNU_IDX_W-1:0]  cnt_q, cnt_d;

    logic                  out_valid_q, out_valid_d;
    logic [CNU_DATA_W:0]   out_msg_q, out_msg_d;
    logic [CNU_IDX_W-1:0]  out_idx_q, out_idx_d;
    logic                  out_last_q, out_last_d;

    cnu_row_t              cap;
    logic                  hs;
    logic                  finish;
    logic                  acc;
    logic [CNU_DATA_W:0]   fmt_msg;

    assign in_ready = rst & ~pend_vld_q;

    always_comb begin
        cap    = '{min: min, min2: min2, min_idx: min_idx, signs: signs, s: ^signs};
        hs     = out_valid_q & out_ready;
        finish = hs & (cnt_q == LAST_IDX);
        acc    = in_valid & in_ready;

        state_d    = state_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    act_d   = cap;
                    cnt_d   = '0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (finish) begin
                    cnt_d = '0;
                    if (pend_vld_q) begin
                        act_d      = pend_q;
                        pend_vld_d = 1'b0;
                    end else if (acc) begin
                        act_d = cap;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (hs) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (acc) begin
                        pend_d     = cap;
                        pend_vld_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are formatted from next-state so the registered message lines up
    // with the counter one cycle after acceptance and holds under backpressure.
    cnu_msg_fmt u_fmt (
        .row (act_d),
        .k   (cnt_d),
        .msg (fmt_msg)
    );

    always_comb begin
        out_valid_d = (state_d == ST_EMIT);
        out_msg_d   = out_valid_d ? fmt_msg : '0;
        out_idx_d   = out_valid_d ? cnt_d : '0;
        out_last_d  = out_valid_d & (cnt_d == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            act_q       <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_msg_q   <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_msg_q   <= out_msg_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_msg   = out_msg_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_cnu_msg_gen.sv
// Bench for cnu_msg_gen: fixed vectors, handshake corner sequences and random
// traffic against a row-queue reference model.
module tb_cnu_msg_gen;
    import cnu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] min = '0;
    logic [7:0] min2 = '0;
    logic [7:0] min_idx = '0;
    logic [4:0] signs = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [8:0] out_msg;
    logic [7:0] out_idx;
    logic       out_last;

    always #5 clk = ~clk;

    cnu_msg_gen dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .min       (min),
        .min2      (min2),
        .min_idx   (min_idx),
        .signs     (signs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_msg   (out_msg),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    typedef struct packed {
        logic [7:0] mn;
        logic [7:0] mn2;
        logic [7:0] idx;
        logic [4:0] sg;
    } mrow_t;

    typedef struct {
        mrow_t      r;
        logic [8:0] exp [5];
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    mrow_t mq [$];
    int    mcnt = 0;
    vec_t  tbl [7];

    // Model: rows in flight are a queue (head = row being emitted), at most two.
    function automatic logic [8:0] ref_msg(mrow_t r, int k);
        int mag;
        int magc;
        bit neg;
        mag  = (int'(r.idx) == k) ? int'(r.mn2) : int'(r.mn);
        magc = (mag > CNU_OFFSET) ? mag - CNU_OFFSET : 0;
        neg  = (($countones(r.sg) % 2) == 1) ^ r.sg[k];
        return neg ? 9'(-magc) : 9'(magc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_row(input mrow_t r);
        in_valid = 1'b1;
        min      = r.mn;
        min2     = r.mn2;
        min_idx  = r.idx;
        signs    = r.sg;
    endtask

    task automatic cycle();
        bit    hs;
        bit    acc;
        mrow_t nr;
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_msg", 32'(out_msg), 32'(ref_msg(mq[0], mcnt)));
            chk("out_idx", 32'(out_idx), 32'(mcnt));
            chk("out_last", 32'(out_last), 32'(mcnt == CNU_D - 1));
        end
        hs  = out_ready && (mq.size() > 0);
        acc = in_valid && (mq.size() < 2);
        nr  = '{mn: min, mn2: min2, idx: min_idx, sg: signs};
        @(posedge clk);
        #1;
        if (hs) begin
            mcnt++;
            if (mcnt == CNU_D) begin
                void'(mq.pop_front());
                mcnt = 0;
            end
        end
        if (acc) mq.push_back(nr);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    logic [8:0] h_msg;
    logic [7:0] h_idx;
    logic       h_last;

    initial begin
        tbl[0] = '{'{8'd3, 8'd7, 8'd2, 5'b00000},   '{9'h002, 9'h002, 9'h006, 9'h002, 9'h002}};
        tbl[1] = '{'{8'd3, 8'd7, 8'd2, 5'b00101},   '{9'h1FE, 9'h002, 9'h1FA, 9'h002, 9'h002}};
        tbl[2] = '{'{8'd0, 8'd1, 8'd0, 5'b00001},   '{9'h000, 9'h000, 9'h000, 9'h000, 9'h000}};
        tbl[3] = '{'{8'd4, 8'd9, 8'd7, 5'b00000},   '{9'h003, 9'h003, 9'h003, 9'h003, 9'h003}};
        tbl[4] = '{'{8'd1, 8'd2, 8'd4, 5'b10011},   '{9'h000, 9'h000, 9'h000, 9'h000, 9'h001}};
        tbl[5] = '{'{8'd200, 8'd255, 8'd1, 5'b11111}, '{9'h0C7, 9'h0FE, 9'h0C7, 9'h0C7, 9'h0C7}};
        tbl[6] = '{'{8'd255, 8'd255, 8'd3, 5'b01000}, '{9'h102, 9'h102, 9'h102, 9'h0FE, 9'h102}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_msg", 32'(out_msg), 0);
        chk("rst_out_idx", 32'(out_idx), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        rst = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 1);
        idle(2);

        // Fixed vectors, one row at a time
        for (int i = 0; i < 7; i++) begin
            set_row(tbl[i].r);
            cycle();
            in_valid = 1'b0;
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("tbl%0d_valid_e%0d", i, k), 32'(out_valid), 1);
                chk($sformatf("tbl%0d_msg_e%0d", i, k), 32'(out_msg), 32'(tbl[i].exp[k]));
                chk($sformatf("tbl%0d_last_e%0d", i, k), 32'(out_last), 32'(k == 4));
                cycle();
            end
            chk($sformatf("tbl%0d_end", i), 32'(out_valid), 0);
            idle(1);
        end

        // Back-to-back rows: ten valid cycles, pending slot gates in_ready
        set_row(tbl[0].r);
        cycle();
        set_row(tbl[1].r);
        cycle();
        in_valid = 1'b0;
        for (int j = 2; j <= 10; j++) begin
            chk("b2b_valid", 32'(out_valid), 1);
            if (j == 5) chk("b2b_pend_full", 32'(in_ready), 0);
            if (j == 6) chk("b2b_pend_free", 32'(in_ready), 1);
            cycle();
        end
        chk("b2b_end", 32'(out_valid), 0);
        idle(1);

        // Backpressure at edge 2 for three cycles
        set_row(tbl[1].r);
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("bp_idx", 32'(out_idx), 2);
        h_msg  = out_msg;
        h_idx  = out_idx;
        h_last = out_last;
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            cycle();
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_msg", 32'(out_msg), 32'(h_msg));
            chk("bp_hold_idx", 32'(out_idx), 32'(h_idx));
            chk("bp_hold_last", 32'(out_last), 32'(h_last));
        end
        out_ready = 1'b1;
        chk("bp_resume_idx", 32'(out_idx), 2);
        idle(4);
        chk("bp_end", 32'(out_valid), 0);

        // Reset with edge 2 out and a second row pending
        set_row(tbl[0].r);
        cycle();
        set_row(tbl[3].r);
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("mr_idx", 32'(out_idx), 2);
        rst = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 0);
        chk("mr_in_ready", 32'(in_ready), 0);
        chk("mr_out_msg", 32'(out_msg), 0);
        mq.delete();
        mcnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mr_rel_in_ready", 32'(in_ready), 1);
        idle(3);
        set_row(tbl[5].r);
        cycle();
        in_valid = 1'b0;
        chk("mr_new_idx", 32'(out_idx), 0);
        chk("mr_new_msg", 32'(out_msg), 32'(tbl[5].exp[0]));
        idle(6);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            min       = 8'($urandom_range(0, 255));
            min2      = 8'($urandom_range(0, 255));
            min_idx   = 8'($urandom_range(0, 7));
            signs     = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        out_ready = 1'b1;
        idle(12);
        chk("rand_drain", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
